// File: rtl/adpll_lock_detector.sv
// adpll_lock_detector
//   Debounced lock monitor for one network ADPLL node. gen_div8_i is
//   synchronised into fpga_clk_i and its rising edge becomes a one-cycle
//   sample strobe. On each strobe the phase error (and optionally the DCO
//   code) is classified as good/bad, driving a 4-state hysteretic lock FSM.
//   A watchdog flags a stalled generated clock.
//
//   Optional feature macro: LOCK_DET_SAT_CHECK_EN
//     When defined, a saturated DCO code counts as a bad sample and the
//     extra output sat_o reports the last sampled saturation status.
//
// Ports
//   fpga_clk_i    system clock
//   reset_n_i     asynchronous active-low reset
//   enable_i      detector enable (low: UNLOCKED, counters cleared)
//   gen_div8_i    divided ADPLL clock, asynchronous to fpga_clk_i
//   error_i       signed phase error, PDET_WIDTH bits
//   dco_cc_i      signed DCO control code, DCO_CC_WIDTH bits
//   locked_o      high in LOCKED and SLIPPING
//   lock_state_o  00 UNLOCKED, 01 ACQUIRING, 10 LOCKED, 11 SLIPPING
//   stall_o       no gen_div8 edge seen for TIMEOUT cycles
//   run_cnt_o     good-run (ACQUIRING) / bad-run (SLIPPING) count, else 0
//   sat_o         (LOCK_DET_SAT_CHECK_EN only) DCO code saturated
module adpll_lock_detector #(
    parameter int unsigned PDET_WIDTH    = 8,
    parameter int unsigned DCO_CC_WIDTH  = 9,
    parameter int unsigned LOCK_THRESH   = 2,
    parameter int unsigned UNLOCK_THRESH = 6,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned UNLOCK_COUNT  = 4,
    parameter int unsigned CNT_WIDTH     = 8,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic                           fpga_clk_i,
    input  logic                           reset_n_i,
    input  logic                           enable_i,
    input  logic                           gen_div8_i,
    input  logic signed [PDET_WIDTH-1:0]   error_i,
    input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
    output logic                           locked_o,
    output logic [1:0]                     lock_state_o,
    output logic                           stall_o,
    output logic [CNT_WIDTH-1:0]           run_cnt_o
`ifdef LOCK_DET_SAT_CHECK_EN
    ,
    output logic                           sat_o
`endif
);

    localparam int unsigned MAG_WIDTH = PDET_WIDTH + 1;
    localparam int unsigned TO_WIDTH  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_LAST = CNT_WIDTH'(UNLOCK_COUNT - 1);
    localparam logic [TO_WIDTH-1:0]  TO_MAX      = TO_WIDTH'(TIMEOUT);
    localparam logic [TO_WIDTH-1:0]  TO_PRE      = TO_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'b00,
        ST_ACQUIRING = 2'b01,
        ST_LOCKED    = 2'b10,
        ST_SLIPPING  = 2'b11
    } state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   run_q;
    logic [TO_WIDTH-1:0]    tcnt_q;
    logic                   stall_q;
    logic [2:0]             sync_q;
    logic                   pulse_q;

    // Two-flop synchroniser plus edge-detect stage; runs regardless of enable
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q  <= 3'b000;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], gen_div8_i};
            pulse_q <= sync_q[1] & ~sync_q[2];
        end
    end

    // |error| in one extra bit so the most negative code cannot alias to a small value
    logic [MAG_WIDTH-1:0] err_ext;
    logic [MAG_WIDTH-1:0] err_mag;
    logic                 good_err;
    logic                 bad_err;

    assign err_ext  = {error_i[PDET_WIDTH-1], error_i};
    assign err_mag  = error_i[PDET_WIDTH-1] ? (~err_ext + MAG_WIDTH'(1)) : err_ext;
    assign good_err = (err_mag <= MAG_WIDTH'(LOCK_THRESH));
    assign bad_err  = (err_mag >  MAG_WIDTH'(UNLOCK_THRESH));

    logic good;
    logic bad;

`ifdef LOCK_DET_SAT_CHECK_EN
    localparam logic [DCO_CC_WIDTH-1:0] DCO_MAX = {1'b0, {(DCO_CC_WIDTH-1){1'b1}}};
    localparam logic [DCO_CC_WIDTH-1:0] DCO_MIN = {1'b1, {(DCO_CC_WIDTH-1){1'b0}}};

    logic [DCO_CC_WIDTH-1:0] dco_bits;
    logic                    sat_c;
    logic                    sat_q;

    assign dco_bits = dco_cc_i;
    assign sat_c    = (dco_bits == DCO_MAX) || (dco_bits == DCO_MIN);
    assign good     = good_err & ~sat_c;
    assign bad      = bad_err | sat_c;

    // Saturation flag tracks the most recent enabled sample
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sat_q <= 1'b0;
        end else if (enable_i && pulse_q) begin
            sat_q <= sat_c;
        end
    end

    assign sat_o = sat_q;
`else
    logic unused_dco;
    assign unused_dco = ^dco_cc_i;
    assign good       = good_err;
    assign bad        = bad_err;
`endif

    // Lock FSM, run counter and stall watchdog
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_UNLOCKED;
            run_q   <= '0;
            tcnt_q  <= '0;
            stall_q <= 1'b0;
        end else if (!enable_i) begin
            state_q <= ST_UNLOCKED;
            run_q   <= '0;
            tcnt_q  <= '0;
            stall_q <= 1'b0;
        end else if (!pulse_q) begin
            if (tcnt_q != TO_MAX) begin
                tcnt_q <= tcnt_q + TO_WIDTH'(1);
            end
            // Entering or sitting at the timeout holds the FSM in UNLOCKED
            if (tcnt_q >= TO_PRE) begin
                stall_q <= 1'b1;
                state_q <= ST_UNLOCKED;
                run_q   <= '0;
            end
        end else begin
            tcnt_q  <= '0;
            stall_q <= 1'b0;
            case (state_q)
                ST_UNLOCKED: begin
                    if (good) begin
                        if (LOCK_COUNT == 1) begin
                            state_q <= ST_LOCKED;
                            run_q   <= '0;
                        end else begin
                            state_q <= ST_ACQUIRING;
                            run_q   <= CNT_WIDTH'(1);
                        end
                    end
                end
                ST_ACQUIRING: begin
                    if (!good) begin
                        state_q <= ST_UNLOCKED;
                        run_q   <= '0;
                    end else if (run_q == LOCK_LAST) begin
                        state_q <= ST_LOCKED;
                        run_q   <= '0;
                    end else begin
                        run_q   <= run_q + CNT_WIDTH'(1);
                    end
                end
                ST_LOCKED: begin
                    if (bad) begin
                        if (UNLOCK_COUNT == 1) begin
                            state_q <= ST_UNLOCKED;
                            run_q   <= '0;
                        end else begin
                            state_q <= ST_SLIPPING;
                            run_q   <= CNT_WIDTH'(1);
                        end
                    end
                end
                ST_SLIPPING: begin
                    if (!bad) begin
                        state_q <= ST_LOCKED;
                        run_q   <= '0;
                    end else if (run_q == UNLOCK_LAST) begin
                        state_q <= ST_UNLOCKED;
                        run_q   <= '0;
                    end else begin
                        run_q   <= run_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= ST_UNLOCKED;
                    run_q   <= '0;
                end
            endcase
        end
    end

    assign lock_state_o = state_q;
    assign locked_o     = state_q[1];
    assign stall_o      = stall_q;
    assign run_cnt_o    = run_q;

endmodule
